mc_control_seq: RTL
===================

Name: mc_control_seq

Overview:
Multi-cycle instruction sequencer for the non-pipelined MIPS datapath. It accepts one 32-bit instruction at a time through a valid/ready handshake and decodes it. It then drives the register file's read_reg1/read_reg2/write_reg/reg_write ports, ALU control and the data-memory request lines, stepping through one phase per cycle. It sits directly upstream of the register file: it sources every register-file address and write enable.

Parameters:
REG_ADDR_W, 5, register address width (32 registers)
INSTR_W, 32, instruction width
MEM_TIMEOUT, 15, max cycles in MEM waiting for mem_ack before error abort

Ports:
clk  in  1  clock, all state changes on posedge
rst  in  1  synchronous, active-high reset
instr  in  INSTR_W  instruction word
instr_valid  in  1  instr holds a valid instruction
instr_ready  out  1  sequencer idle, accepts instr this cycle
read_reg1  out  REG_ADDR_W  rs, to register file
read_reg2  out  REG_ADDR_W  rt, to register file
write_reg  out  REG_ADDR_W  destination, to register file
reg_write  out  1  register-file write enable
imm  out  16  instr[15:0]
alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT
alu_src  out  1  1 = ALU operand B is imm
mem_read  out  1  load request, held until mem_ack
mem_write  out  1  store request, held until mem_ack
mem_ack  in  1  memory completed request
branch  out  1  one-cycle pulse, beq evaluated this cycle
done  out  1  one-cycle pulse, instruction retired
error  out  1  one-cycle pulse, illegal opcode/funct or memory timeout

Behaviour:
- Reset: state IDLE. Instruction register, counter and all outputs are 0, including instr_ready while rst=1. rst mid-instruction aborts with no reg_write and no done.
- Outputs are decoded from state plus the captured instruction register (IR). No combinational path from instr to any output except instr_ready.
- Supported: R-type (op 000000) funct add 100000, sub 100010, and 100100, or 100101, slt 101010; addi 001000; lw 100011; sw 101011; beq 000100.
- IDLE: instr_ready=1. If instr_valid=1, capture IR, go to DECODE. Otherwise stay.
- DECODE: if opcode/funct unsupported, pulse error and go to IDLE. Otherwise go to READ.
- READ: read_reg1=IR[25:21], read_reg2=IR[20:16], reg_write=0. The register file registers its outputs, so one cycle is reserved here. Go to EXEC.
- EXEC: alu_op and alu_src valid. alu_src=1 for addi/lw/sw. ADD for addi/lw/sw, SUB for beq.
  - beq: pulse branch and done, go to IDLE.
  - lw/sw: go to MEM.
  - R-type/addi: go to WB.
- MEM: mem_read (lw) or mem_write (sw) held high; the counter increments each cycle.
  - mem_ack=1: lw goes to WB; sw pulses done and goes to IDLE.
  - Counter reaches MEM_TIMEOUT without ack: drop the request, pulse error, go to IDLE, no write.
  - The counter clears on MEM entry.
- WB: write_reg = IR[15:11] for R-type, IR[20:16] for addi/lw. reg_write=1 for exactly one cycle, then pulse done and go to IDLE.
  - If write_reg==0, reg_write stays 0 (r0 protected) but done still pulses.
- read_reg1/read_reg2 hold their READ values through EXEC/MEM/WB. They are 0 in IDLE.
- Latency from handshake cycle T:
  - R-type/addi: done at T+4.
  - beq: done at T+3.
  - sw with immediate ack: done at T+4.
  - lw with immediate ack: done at T+5.
- reg_write is never 1 in READ, so reads and writes never collide.
- instr_valid while not IDLE is ignored (instr_ready=0). Throughput is at most one instruction per 4 cycles.

Decomposition:
- Shared package mips_ctrl_pkg: opcode/funct constants, alu_op encodings, state enum (IDLE, DECODE, READ, EXEC, MEM, WB).
- One sub-module, mc_instr_decoder: combinational IR to {is_rtype, is_addi, is_lw, is_sw, is_beq, illegal, alu_op, alu_src, dest_sel}.
- The FSM and timeout counter stay in mc_control_seq.

Test Plan:
- add $3,$1,$2 (0x00221820), valid at T -> read_reg1=1, read_reg2=2 in READ. At T+4: reg_write=1, write_reg=3, done=1.
- addi $0,$5,7 (0x20A00007) -> alu_src=1, alu_op=000 in EXEC. reg_write stays 0 in WB, done at T+4.
- lw $4,8($2) (0x8C440008), mem_ack 3 cycles after MEM entry -> mem_read high 3 cycles, then WB write_reg=4, reg_write=1.
- sw with mem_ack never asserted -> mem_write drops after 15 MEM cycles, error pulses, no done, instr_ready=1 next cycle.
- Opcode 0x3F, or R-type funct 000000 -> error pulse at T+1, no register-file activity, back to IDLE.
- rst asserted during lw MEM -> next cycle all outputs 0. After release instr_ready=1 and no reg_write ever occurs.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer.
// Contents: opcode/funct encodings of the supported subset, ALU operation
// codes driven to the datapath, destination-select encoding and the
// sequencer state enumeration.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_op_t;

  typedef enum logic {
    DEST_RT = 1'b0,
    DEST_RD = 1'b1
  } dest_sel_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

endpackage

// File: rtl/mc_instr_decoder.sv
// Combinational instruction decoder for the multi-cycle sequencer.
// Ports:
//   opcode   in   instruction bits [31:26]
//   funct    in   instruction bits [5:0]
//   is_*     out  instruction class flags (one-hot when legal)
//   illegal  out  opcode or R-type funct outside the supported subset
//   alu_op   out  ALU operation for the EXEC phase
//   alu_src  out  1 = ALU operand B comes from the immediate
//   dest_sel out  destination field select (rd for R-type, rt otherwise)
module mc_instr_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       is_rtype,
  output logic       is_addi,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_beq,
  output logic       illegal,
  output alu_op_t    alu_op,
  output logic       alu_src,
  output dest_sel_t  dest_sel
);

  always_comb begin
    is_rtype = 1'b0;
    is_addi  = 1'b0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    is_beq   = 1'b0;
    illegal  = 1'b0;
    alu_op   = ALU_ADD;
    alu_src  = 1'b0;
    dest_sel = DEST_RT;
    case (opcode)
      OP_RTYPE: begin
        is_rtype = 1'b1;
        dest_sel = DEST_RD;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        is_addi = 1'b1;
        alu_src = 1'b1;
      end
      OP_LW: begin
        is_lw   = 1'b1;
        alu_src = 1'b1;
      end
      OP_SW: begin
        is_sw   = 1'b1;
        alu_src = 1'b1;
      end
      // beq compares rs and rt by subtraction
      OP_BEQ: begin
        is_beq = 1'b1;
        alu_op = ALU_SUB;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_seq.sv
// Multi-cycle instruction sequencer for the non-pipelined MIPS datapath.
// Accepts one instruction via instr_valid/instr_ready, then walks
// DECODE -> READ -> EXEC -> (MEM) -> (WB), one phase per cycle, sourcing
// every register-file address and write enable plus ALU and memory controls.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   instr, instr_valid     instruction word and its valid flag
//   instr_ready            idle, instruction accepted this cycle
//   read_reg1/read_reg2    rs/rt to register file (held READ..WB)
//   write_reg, reg_write   destination and write enable (WB only)
//   imm                    immediate field of the captured instruction
//   alu_op, alu_src        ALU control (EXEC onward)
//   mem_read, mem_write    memory request, held until mem_ack
//   mem_ack                memory completion
//   branch, done, error    single-cycle status pulses
module mc_control_seq
  import mips_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int INSTR_W     = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INSTR_W-1:0]    instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  output logic [REG_ADDR_W-1:0] read_reg1,
  output logic [REG_ADDR_W-1:0] read_reg2,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic                  reg_write,
  output logic [15:0]           imm,
  output logic [2:0]            alu_op,
  output logic                  alu_src,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic                  mem_ack,
  output logic                  branch,
  output logic                  done,
  output logic                  error
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t             state, state_next;
  logic [INSTR_W-1:0] ir;
  logic [CNT_W-1:0]   cnt;

  logic      is_rtype, is_addi, is_lw, is_sw, is_beq, illegal;
  logic      dec_alu_src;
  alu_op_t   dec_alu_op;
  dest_sel_t dest_sel;

  logic [REG_ADDR_W-1:0] rs, rt, dest;
  logic                  timeout;

  mc_instr_decoder u_dec (
    .opcode   (ir[31:26]),
    .funct    (ir[5:0]),
    .is_rtype (is_rtype),
    .is_addi  (is_addi),
    .is_lw    (is_lw),
    .is_sw    (is_sw),
    .is_beq   (is_beq),
    .illegal  (illegal),
    .alu_op   (dec_alu_op),
    .alu_src  (dec_alu_src),
    .dest_sel (dest_sel)
  );

  assign rs      = REG_ADDR_W'(ir[25:21]);
  assign rt      = REG_ADDR_W'(ir[20:16]);
  assign dest    = (dest_sel == DEST_RD) ? REG_ADDR_W'(ir[15:11]) : rt;
  assign timeout = (cnt == CNT_W'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && instr_valid)
        ir <= instr;
      // counter is zeroed on the way into MEM and counts MEM cycles spent
      if (state == S_EXEC)
        cnt <= '0;
      else if (state == S_MEM && !timeout)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    read_reg1   = '0;
    read_reg2   = '0;
    write_reg   = '0;
    reg_write   = 1'b0;
    imm         = ir[15:0];
    alu_op      = ALU_ADD;
    alu_src     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    branch      = 1'b0;
    done        = 1'b0;
    error       = 1'b0;

    // rs/rt and ALU controls stay stable from their first phase to retire
    if (state == S_READ || state == S_EXEC || state == S_MEM || state == S_WB) begin
      read_reg1 = rs;
      read_reg2 = rt;
    end
    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      alu_op  = dec_alu_op;
      alu_src = dec_alu_src;
    end

    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid)
          state_next = S_DECODE;
      end
      S_DECODE: begin
        if (illegal) begin
          error      = 1'b1;
          state_next = S_IDLE;
        end else begin
          state_next = S_READ;
        end
      end
      // register file output is registered; this phase only presents addresses
      S_READ: state_next = S_EXEC;
      S_EXEC: begin
        if (is_beq) begin
          branch     = 1'b1;
          done       = 1'b1;
          state_next = S_IDLE;
        end else if (is_lw || is_sw) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (timeout) begin
          error      = 1'b1;
          state_next = S_IDLE;
        end else begin
          mem_read  = is_lw;
          mem_write = is_sw;
          if (mem_ack) begin
            if (is_lw) begin
              state_next = S_WB;
            end else begin
              done       = 1'b1;
              state_next = S_IDLE;
            end
          end
        end
      end
      // r0 is hard-wired zero: never write it, but still retire
      S_WB: begin
        write_reg  = dest;
        reg_write  = (is_rtype || is_addi || is_lw) && (dest != '0);
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // outputs are forced quiet while reset is held
    if (rst) begin
      instr_ready = 1'b0;
      read_reg1   = '0;
      read_reg2   = '0;
      write_reg   = '0;
      reg_write   = 1'b0;
      imm         = '0;
      alu_op      = ALU_ADD;
      alu_src     = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      branch      = 1'b0;
      done        = 1'b0;
      error       = 1'b0;
    end
  end

endmodule
